// File: rtl/inst_itf_resp.sv
// Instruction fetch responder: one-entry line buffer in front of a
// fixed-latency SRAM. Requests are range/alignment checked, served from the
// buffer on a hit, or read from SRAM on a miss. All outputs are registered.
module inst_itf_resp #(
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter logic [31:0] END_ADDR    = 32'h0fff,
  parameter int          WAIT_CYCLES = 2,
  parameter int          SRAM_AW     = 10
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               inst_req_i,
  input  logic [31:0]        inst_addr_i,
  output logic               inst_ack_o,
  output logic [31:0]        inst_data_o,
  output logic               inst_error_o,
  input  logic               flush_i,
  output logic               sram_en_o,
  output logic [SRAM_AW-1:0] sram_addr_o,
  input  logic [31:0]        sram_rdata_i,
  output logic               busy_o
);

  typedef enum logic [2:0] {IDLE, CHECK, READ, WAIT, RESP} state_t;

  localparam logic [31:0] SPAN    = END_ADDR - BASE_ADDR;
  localparam logic [3:0]  WAIT_LD = 4'(WAIT_CYCLES);

  state_t       state, state_nx;
  logic [31:0]  addr_q;
  logic [3:0]   cnt_q;
  logic         flush_seen;
  logic         buf_valid;
  logic [31:0]  buf_tag, buf_data;

  logic [31:0]  offset;
  logic         addr_err, hit;
  logic         ack_nx, err_nx, en_nx, load;
  logic [31:0]  data_nx;

  // Offset from the base doubles as the range check (wraps when below base)
  // and as the SRAM word address source.
  assign offset   = addr_q - BASE_ADDR;
  assign addr_err = (offset > SPAN) || (addr_q[1:0] != 2'b00);
  assign hit      = buf_valid && (buf_tag == addr_q) && !flush_i;

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nx;
  end

  // Next state and next values of the registered outputs.
  always_comb begin
    state_nx = state;
    ack_nx   = 1'b0;
    err_nx   = 1'b0;
    en_nx    = 1'b0;
    data_nx  = 32'h0;
    load     = 1'b0;
    case (state)
      IDLE:  if (inst_req_i) state_nx = CHECK;
      CHECK: begin
        if (addr_err) begin
          state_nx = RESP;
          ack_nx   = 1'b1;
          err_nx   = 1'b1;
        end else if (hit) begin
          state_nx = RESP;
          ack_nx   = 1'b1;
          data_nx  = buf_data;
        end else begin
          state_nx = READ;
          en_nx    = 1'b1;
        end
      end
      READ:  state_nx = WAIT;
      WAIT: begin
        if (cnt_q == 4'd1) begin
          state_nx = RESP;
          ack_nx   = 1'b1;
          data_nx  = sram_rdata_i;
          load     = !flush_seen && !flush_i;
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Request capture, wait counter and per-transaction flush tracking.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q     <= 32'h0;
      cnt_q      <= 4'd0;
      flush_seen <= 1'b0;
    end else begin
      if (state == IDLE && inst_req_i) begin
        addr_q     <= inst_addr_i;
        flush_seen <= flush_i;
      end else if (flush_i) begin
        flush_seen <= 1'b1;
      end
      if (state == READ)      cnt_q <= WAIT_LD;
      else if (state == WAIT) cnt_q <= cnt_q - 4'd1;
    end
  end

  // Line buffer: flush always wins over a fill in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      buf_valid <= 1'b0;
      buf_tag   <= 32'h0;
      buf_data  <= 32'h0;
    end else begin
      if (flush_i)   buf_valid <= 1'b0;
      else if (load) buf_valid <= 1'b1;
      if (load) begin
        buf_tag  <= addr_q;
        buf_data <= sram_rdata_i;
      end
    end
  end

  // Registered outputs; data/error are zero whenever ack is low.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      inst_ack_o   <= 1'b0;
      inst_error_o <= 1'b0;
      inst_data_o  <= 32'h0;
      sram_en_o    <= 1'b0;
      sram_addr_o  <= '0;
      busy_o       <= 1'b0;
    end else begin
      inst_ack_o   <= ack_nx;
      inst_error_o <= err_nx;
      inst_data_o  <= data_nx;
      sram_en_o    <= en_nx;
      if (en_nx) sram_addr_o <= SRAM_AW'(offset >> 2);
      busy_o       <= (state_nx != IDLE);
    end
  end

endmodule

// File: doc/inst_itf_resp.md
INST_ITF_RESP -- requirements
Module: inst_itf_resp

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter BASE_ADDR, default 32'h0, is the lowest instruction address served.
REQ-003 Parameter END_ADDR, default 32'h0fff, is the highest instruction address served, inclusive.
REQ-004 Parameter WAIT_CYCLES, default 2, is the SRAM read latency in cycles; legal range 1..15.
REQ-005 Parameter SRAM_AW, default 10, is the SRAM word-address width.
REQ-006 Ports SHALL be, clock and reset first:
- clk_i  in  1  block clock, posedge.
- rst_i  in  1  synchronous reset, active high.
- inst_req_i  in  1  fetch request, held until ack.
- inst_addr_i  in  32  fetch byte address, valid while inst_req_i=1.
- inst_ack_o  out  1  one-cycle response strobe.
- inst_data_o  out  32  instruction word, valid with ack.
- inst_error_o  out  1  access error, valid with ack.
- flush_i  in  1  invalidates the line buffer.
- sram_en_o  out  1  SRAM read enable, one-cycle pulse.
- sram_addr_o  out  SRAM_AW  SRAM word address.
- sram_rdata_i  in  32  SRAM read data.
- busy_o  out  1  high when the FSM is not IDLE.

Function
REQ-007 All outputs SHALL be driven from registers.
REQ-008 The FSM SHALL have states IDLE, CHECK, READ, WAIT and RESP.
REQ-009 In IDLE with inst_req_i=1 in cycle T, the block SHALL latch inst_addr_i and enter CHECK at T+1.
- If inst_req_i=0 in IDLE, the block SHALL stay in IDLE.
REQ-010 CHECK SHALL classify the latched address, with the first matching rule taking effect:
- error, when addr < BASE_ADDR, addr > END_ADDR, or addr[1:0] != 0;
- hit, when the line buffer is valid, its tag equals addr, and flush_i=0;
- miss, otherwise.
REQ-011 On error or hit, the block SHALL go CHECK -> RESP, giving inst_ack_o at T+2.
REQ-012 On a miss, the block SHALL go CHECK -> READ.
- In READ, sram_en_o=1 for exactly one cycle (T+2).
- sram_addr_o SHALL be ((addr - BASE_ADDR) >> 2) truncated to SRAM_AW bits.
REQ-013 WAIT SHALL last exactly WAIT_CYCLES cycles, counted by a 4-bit down-counter.
- sram_rdata_i SHALL be sampled in the last WAIT cycle.
- A miss therefore gives inst_ack_o at T+3+WAIT_CYCLES.
REQ-014 RESP SHALL last one cycle, with inst_ack_o=1, then return to IDLE.
- A request present in the RESP cycle SHALL NOT start a new transaction.
REQ-015 Response data SHALL be as follows:
- error: inst_data_o=0, inst_error_o=1, no SRAM access, line buffer unchanged.
- hit: buffer data, inst_error_o=0, sram_en_o stays 0.
- miss: sampled SRAM word, inst_error_o=0.
REQ-016 On each miss completion, the line buffer SHALL load tag=addr and data=SRAM word, and set valid, unless flush_i was asserted at any point during that transaction.
REQ-017 flush_i=1 in any cycle SHALL clear the buffer valid bit at the next edge.
- flush_i SHALL NOT abort a transaction in flight.
REQ-018 If inst_req_i drops mid-transaction, the transaction SHALL still complete with an ack.
REQ-019 When inst_ack_o=0, inst_data_o and inst_error_o SHALL hold 0.
REQ-020 busy_o SHALL be 1 in every state except IDLE.

Reset
REQ-021 While rst_i=1 at a clk_i edge, the block SHALL:
- enter IDLE;
- clear inst_ack_o, inst_error_o, inst_data_o, sram_en_o, sram_addr_o, busy_o, the wait counter, and the buffer valid bit.
REQ-022 Reset mid-transaction SHALL abandon the transaction with no ack and no buffer update.
REQ-023 After reset deasserts, the first transaction SHALL be a miss.

Verification
REQ-024 Cold miss: WAIT_CYCLES=2; req at T with addr 0x100; SRAM returns 0x00000013 -> sram_en_o at T+2 with sram_addr_o=0x40; ack at T+5 with data 0x00000013 and error=0.
REQ-025 Hit: repeat fetch of 0x100 -> ack at T+2 with data 0x00000013 and no sram_en_o pulse.
REQ-026 Errors:
- addr 0x1000 -> ack at T+2, error=1, data=0.
- addr 0x102 -> ack at T+2, error=1, data=0.
- Neither case pulses sram_en_o.
REQ-027 Flush during a miss to 0x200: flush_i high in the WAIT state -> ack carries the SRAM data; a following fetch of 0x200 is a miss.
REQ-028 Reset in the WAIT state -> no ack, busy_o=0 on the next cycle; a subsequent fetch of 0x100 is a miss.
REQ-029 Back-to-back: req held through the ack cycle, then deasserted -> exactly one ack pulse and one SRAM read.
